// File: rtl/data_mem_arb_pkg.sv
// Shared FSM/owner types and constants for the data-memory arbiter.
package data_mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
   typedef enum logic {OWN_CORE, OWN_DMA} owner_e;

   localparam logic [2:0] MEM_CTRL_WORD = 3'b010;

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-requester (core/DMA) sequencer for the single data-memory port with MEM_LAT wait states.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise the core always wins.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  coreReq,
   input  logic                  coreWe,
   input  logic [DATA_WIDTH-1:0] coreAddr,
   input  logic [DATA_WIDTH-1:0] coreWdata,
   input  logic [2:0]            coreCtrl,
   output logic                  coreAck,
   output logic [DATA_WIDTH-1:0] coreRdata,
   output logic                  stallM,
   input  logic                  dmaReq,
   input  logic                  dmaWe,
   input  logic [DATA_WIDTH-1:0] dmaAddr,
   input  logic [DATA_WIDTH-1:0] dmaWdata,
   output logic                  dmaAck,
   output logic [DATA_WIDTH-1:0] dmaRdata,
   output logic [DATA_WIDTH-1:0] memA,
   output logic [DATA_WIDTH-1:0] memWd,
   output logic                  memWe,
   output logic [2:0]            memCtrl,
   input  logic [DATA_WIDTH-1:0] memRd
);

   localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   owner_e                owner_q, owner_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [2:0]            ctrl_q, ctrl_d;
   logic                  grant_dma;
   logic                  final_access;
   logic                  in_resp;

   assign final_access = (state_q == ACCESS) && (cnt_q == '0);
   assign in_resp      = (state_q == RESP);

`ifdef ARB_ROUND_ROBIN_EN
   owner_e last_grant_q, last_grant_d;

   // On a tie the DMA wins only if the core took the previous grant.
   always_comb begin
      grant_dma    = dmaReq && (!coreReq || (last_grant_q == OWN_CORE));
      last_grant_d = last_grant_q;
      if ((state_q == IDLE) && (coreReq || dmaReq)) begin
         last_grant_d = grant_dma ? OWN_DMA : OWN_CORE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= OWN_DMA;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   always_comb begin
      grant_dma = dmaReq && !coreReq;
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ctrl_d  = ctrl_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (coreReq || dmaReq) begin
               state_d = ACCESS;
               cnt_d   = CNT_LOAD;
               if (grant_dma) begin
                  owner_d = OWN_DMA;
                  we_d    = dmaWe;
                  addr_d  = dmaAddr;
                  wdata_d = dmaWdata;
                  ctrl_d  = MEM_CTRL_WORD;
               end else begin
                  owner_d = OWN_CORE;
                  we_d    = coreWe;
                  addr_d  = coreAddr;
                  wdata_d = coreWdata;
                  ctrl_d  = coreCtrl;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               rdata_d = memRd;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The memory only sees the latched access while in ACCESS; the write strobe fires once, on the last cycle.
   always_comb begin
      memA      = '0;
      memWd     = '0;
      memCtrl   = '0;
      memWe     = 1'b0;
      if (state_q == ACCESS) begin
         memA    = addr_q;
         memWd   = wdata_q;
         memCtrl = ctrl_q;
         memWe   = we_q && final_access;
      end
      coreAck   = in_resp && (owner_q == OWN_CORE);
      dmaAck    = in_resp && (owner_q == OWN_DMA);
      coreRdata = coreAck ? rdata_q : '0;
      dmaRdata  = dmaAck ? rdata_q : '0;
      stallM    = coreReq && !coreAck;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= OWN_CORE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ctrl_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ctrl_q  <= ctrl_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_data_mem_arbiter;

   localparam int DW  = 32;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst;

   logic          coreReq, coreWe, coreAck, stallM, dmaReq, dmaWe, dmaAck, memWe;
   logic [DW-1:0] coreAddr, coreWdata, coreRdata, dmaAddr, dmaWdata, dmaRdata, memA, memWd, memRd;
   logic [2:0]    coreCtrl, memCtrl;

   logic          l1_coreReq, l1_coreWe, l1_coreAck, l1_stallM, l1_dmaReq, l1_dmaWe, l1_dmaAck, l1_memWe;
   logic [DW-1:0] l1_coreAddr, l1_coreWdata, l1_coreRdata, l1_dmaAddr, l1_dmaWdata, l1_dmaRdata;
   logic [DW-1:0] l1_memA, l1_memWd, l1_memRd;
   logic [2:0]    l1_coreCtrl, l1_memCtrl;

   int checks = 0;
   int failures = 0;

   // Memory device behind the MEM_LAT=2 instance plus a write monitor.
   logic [31:0] dev_mem [16];
   logic [31:0] ref_mem [16];
   int          wr_count = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [2:0]  wr_ctrl = '0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.DATA_WIDTH(DW), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .coreReq(coreReq), .coreWe(coreWe), .coreAddr(coreAddr), .coreWdata(coreWdata), .coreCtrl(coreCtrl),
      .coreAck(coreAck), .coreRdata(coreRdata), .stallM(stallM),
      .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWdata(dmaWdata),
      .dmaAck(dmaAck), .dmaRdata(dmaRdata),
      .memA(memA), .memWd(memWd), .memWe(memWe), .memCtrl(memCtrl), .memRd(memRd)
   );

   data_mem_arbiter #(.DATA_WIDTH(DW), .MEM_LAT(1)) u_dut_lat1 (
      .clk(clk), .rst(rst),
      .coreReq(l1_coreReq), .coreWe(l1_coreWe), .coreAddr(l1_coreAddr), .coreWdata(l1_coreWdata),
      .coreCtrl(l1_coreCtrl), .coreAck(l1_coreAck), .coreRdata(l1_coreRdata), .stallM(l1_stallM),
      .dmaReq(l1_dmaReq), .dmaWe(l1_dmaWe), .dmaAddr(l1_dmaAddr), .dmaWdata(l1_dmaWdata),
      .dmaAck(l1_dmaAck), .dmaRdata(l1_dmaRdata),
      .memA(l1_memA), .memWd(l1_memWd), .memWe(l1_memWe), .memCtrl(l1_memCtrl), .memRd(l1_memRd)
   );

   assign memRd    = dev_mem[memA[5:2]];
   assign l1_memRd = l1_memA ^ 32'hFFFF_0000;

   always @(posedge clk) begin
      if (memWe) begin
         dev_mem[memA[5:2]] = memWd;
         wr_count = wr_count + 1;
         wr_addr  = memA;
         wr_data  = memWd;
         wr_ctrl  = memCtrl;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      coreReq = 0; coreWe = 0; coreAddr = '0; coreWdata = '0; coreCtrl = '0;
      dmaReq = 0; dmaWe = 0; dmaAddr = '0; dmaWdata = '0;
      l1_coreReq = 0; l1_coreWe = 0; l1_coreAddr = '0; l1_coreWdata = '0; l1_coreCtrl = '0;
      l1_dmaReq = 0; l1_dmaWe = 0; l1_dmaAddr = '0; l1_dmaWdata = '0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      checks++;
      if ({coreAck, dmaAck, memWe, memCtrl, stallM} !== 7'b0) begin
         failures++;
         $display("[TB] FAIL reset_ctrl got=%b exp=0", {coreAck, dmaAck, memWe, memCtrl, stallM});
      end
      checks++;
      if ({memA, memWd, coreRdata, dmaRdata} !== 128'b0) begin
         failures++;
         $display("[TB] FAIL reset_data got=%h exp=0", {memA, memWd, coreRdata, dmaRdata});
      end
      coreReq = 1;
      #1;
      checks++;
      if (stallM !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_stall_follows got=%b exp=1", stallM);
      end
      tick();
      checks++;
      if ({coreAck, memWe, memA} !== 34'b0) begin
         failures++;
         $display("[TB] FAIL reset_hold got=%h exp=0", {coreAck, memWe, memA});
      end
      coreReq = 0;
      rst = 0;
   endtask

   task automatic test_core_read();
      reset_dut();
      coreReq = 1; coreWe = 0; coreAddr = 32'h10; coreCtrl = 3'b010;
      #1;
      checks++;
      if (stallM !== 1'b1) begin
         failures++;
         $display("[TB] FAIL read_stall_n got=%b exp=1", stallM);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (stallM !== (k < 3) || coreAck !== (k == 3) || dmaAck !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_timing k=%0d stall=%b ack=%b dack=%b exp stall=%b ack=%b dack=0",
                     k, stallM, coreAck, dmaAck, (k < 3), (k == 3));
         end
         if (k < 3) begin
            checks++;
            if (memA !== 32'h10 || memWe !== 1'b0) begin
               failures++;
               $display("[TB] FAIL read_port k=%0d memA=%h memWe=%b exp memA=10 memWe=0", k, memA, memWe);
            end
         end else begin
            checks++;
            if (coreRdata !== 32'hDEADBEEF) begin
               failures++;
               $display("[TB] FAIL read_data got=%h exp=deadbeef", coreRdata);
            end
         end
      end
      coreReq = 0;
      tick();
      checks++;
      if (coreAck !== 1'b0) begin
         failures++;
         $display("[TB] FAIL read_ack_pulse got=%b exp=0", coreAck);
      end
   endtask

   task automatic test_core_write();
      reset_dut();
      coreReq = 1; coreWe = 1; coreAddr = 32'h20; coreWdata = 32'h12345678; coreCtrl = 3'b010;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (memWe !== (k == 2)) begin
            failures++;
            $display("[TB] FAIL write_we k=%0d got=%b exp=%b", k, memWe, (k == 2));
         end
         if (k == 2) begin
            checks++;
            if ({memA, memWd, memCtrl} !== {32'h20, 32'h12345678, 3'b010}) begin
               failures++;
               $display("[TB] FAIL write_port got=%h/%h/%b exp=20/12345678/010", memA, memWd, memCtrl);
            end
         end
         if (k == 3) begin
            checks++;
            if (coreAck !== 1'b1 || dmaAck !== 1'b0) begin
               failures++;
               $display("[TB] FAIL write_ack got core=%b dma=%b exp core=1 dma=0", coreAck, dmaAck);
            end
         end
      end
      ref_mem[8] = 32'h12345678;
      coreReq = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [23:0] order, exp_order;
      int nc, nd, n, prev, exp_k;
      reset_dut();
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = "CDC";
`else
      exp_order = "CCD";
`endif
      order = '0; nc = 0; nd = 0; n = 0; prev = 0;
      coreReq = 1; coreWe = 0; coreAddr = 32'h04; coreCtrl = 3'b010;
      dmaReq = 1; dmaWe = 0; dmaAddr = 32'h08;
      for (int k = 1; k <= 40 && !(nc == 2 && nd == 1); k++) begin
         tick();
         if (coreAck || dmaAck) begin
            exp_k = (n == 0) ? LAT + 1 : prev + LAT + 2;
            checks++;
            if (k !== exp_k) begin
               failures++;
               $display("[TB] FAIL b2b_spacing ack#%0d at=%0d exp=%0d", n, k, exp_k);
            end
            prev = k;
            n++;
         end
         if (coreAck) begin
            checks++;
            if (coreRdata !== ref_mem[coreAddr[5:2]]) begin
               failures++;
               $display("[TB] FAIL b2b_core_data got=%h exp=%h", coreRdata, ref_mem[coreAddr[5:2]]);
            end
            order = {order[15:0], 8'h43};
            nc++;
            if (nc == 1) coreAddr = 32'h0C;
            else coreReq = 0;
         end
         if (dmaAck) begin
            checks++;
            if (dmaRdata !== ref_mem[dmaAddr[5:2]]) begin
               failures++;
               $display("[TB] FAIL b2b_dma_data got=%h exp=%h", dmaRdata, ref_mem[dmaAddr[5:2]]);
            end
            order = {order[15:0], 8'h44};
            nd++;
            dmaReq = 0;
         end
      end
      checks++;
      if (order !== exp_order) begin
         failures++;
         $display("[TB] FAIL b2b_order got=%s exp=%s", order, exp_order);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_dma_then_core();
      reset_dut();
      dmaReq = 1; dmaWe = 0; dmaAddr = 32'h14;
      tick();
      coreReq = 1; coreWe = 0; coreAddr = 32'h18; coreCtrl = 3'b000;
      #1;
      checks++;
      if ({memA, memCtrl, stallM} !== {32'h14, 3'b010, 1'b1}) begin
         failures++;
         $display("[TB] FAIL dma_port_k1 got=%h/%b/%b exp=14/010/1", memA, memCtrl, stallM);
      end
      for (int k = 2; k <= 8; k++) begin
         tick();
         checks++;
         if (stallM !== (k < 7) || dmaAck !== (k == 3) || coreAck !== (k == 7)) begin
            failures++;
            $display("[TB] FAIL dma_core_timing k=%0d stall=%b dack=%b cack=%b exp=%b/%b/%b",
                     k, stallM, dmaAck, coreAck, (k < 7), (k == 3), (k == 7));
         end
         if (k == 2) begin
            checks++;
            if (memCtrl !== 3'b010) begin
               failures++;
               $display("[TB] FAIL dma_ctrl got=%b exp=010", memCtrl);
            end
         end
         if (k == 5) begin
            checks++;
            if ({memA, memCtrl} !== {32'h18, 3'b000}) begin
               failures++;
               $display("[TB] FAIL core_after_dma_port got=%h/%b exp=18/000", memA, memCtrl);
            end
         end
         if (k == 3) begin
            checks++;
            if (dmaRdata !== ref_mem[5]) begin
               failures++;
               $display("[TB] FAIL dma_rdata got=%h exp=%h", dmaRdata, ref_mem[5]);
            end
            dmaReq = 0;
         end
         if (k == 7) begin
            checks++;
            if (coreRdata !== ref_mem[6]) begin
               failures++;
               $display("[TB] FAIL core_after_dma_rdata got=%h exp=%h", coreRdata, ref_mem[6]);
            end
            coreReq = 0;
         end
      end
   endtask

   task automatic test_reset_mid_access();
      int base;
      reset_dut();
      base = wr_count;
      dmaReq = 1; dmaWe = 1; dmaAddr = 32'h0C; dmaWdata = 32'hCAFEF00D;
      tick();
      checks++;
      if ({memWe, memA} !== {1'b0, 32'h0C}) begin
         failures++;
         $display("[TB] FAIL rst_mid_first_access got=%b/%h exp=0/0c", memWe, memA);
      end
      rst = 1;
      dmaReq = 0;
      tick();
      rst = 0;
      checks++;
      if ({coreAck, dmaAck, memWe, memCtrl, stallM, memA, memWd, dmaRdata} !== 103'b0) begin
         failures++;
         $display("[TB] FAIL rst_mid_outputs got=%h exp=0",
                  {coreAck, dmaAck, memWe, memCtrl, stallM, memA, memWd, dmaRdata});
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if ({dmaAck, memWe} !== 2'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_quiet k=%0d got=%b exp=00", k, {dmaAck, memWe});
         end
      end
      checks++;
      if (wr_count !== base) begin
         failures++;
         $display("[TB] FAIL rst_mid_no_write got=%0d exp=%0d", wr_count, base);
      end
      coreReq = 1; coreWe = 0; coreAddr = 32'h0C; coreCtrl = 3'b010;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (coreAck !== (k == 3)) begin
            failures++;
            $display("[TB] FAIL rst_mid_followup_ack k=%0d got=%b exp=%b", k, coreAck, (k == 3));
         end
      end
      checks++;
      if (coreRdata !== ref_mem[3]) begin
         failures++;
         $display("[TB] FAIL rst_mid_followup_data got=%h exp=%h", coreRdata, ref_mem[3]);
      end
      coreReq = 0;
      tick();
   endtask

   task automatic test_lat1_back_to_back();
      int n, prev, exp_k;
      reset_dut();
      n = 0; prev = 0;
      l1_coreReq = 1; l1_coreWe = 0; l1_coreAddr = 32'h100; l1_coreCtrl = 3'b010;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (l1_coreAck) begin
            n++;
            exp_k = (n == 1) ? 2 : prev + 3;
            checks++;
            if (k !== exp_k) begin
               failures++;
               $display("[TB] FAIL lat1_spacing ack#%0d at=%0d exp=%0d", n, k, exp_k);
            end
            checks++;
            if (l1_coreRdata !== (l1_coreAddr ^ 32'hFFFF_0000)) begin
               failures++;
               $display("[TB] FAIL lat1_data got=%h exp=%h", l1_coreRdata, l1_coreAddr ^ 32'hFFFF_0000);
            end
            prev = k;
            if (n < 3) l1_coreAddr = l1_coreAddr + 32'h40;
            else l1_coreReq = 0;
         end
      end
      checks++;
      if (n !== 3) begin
         failures++;
         $display("[TB] FAIL lat1_ack_count got=%0d exp=3", n);
      end
   endtask

   // Transaction-level model: each requester holds until acked, grants are serialized MEM_LAT+2 apart.
   task automatic test_random();
      bit last_core;
      reset_dut();
      last_core = 1'b0;
      for (int it = 0; it < 40; it++) begin
         int          pat, c_k, d_k, base, nwr;
         bit          c_on, d_on, c_we, d_we, core_first;
         logic [3:0]  c_idx, d_idx;
         logic [31:0] c_wd, d_wd;
         logic [2:0]  c_ctrl;
         pat    = $urandom_range(0, 2);
         c_on   = (pat != 1);
         d_on   = (pat != 0);
         c_we   = 1'($urandom_range(0, 1));
         d_we   = 1'($urandom_range(0, 1));
         c_idx  = 4'($urandom_range(0, 15));
         d_idx  = 4'($urandom_range(0, 15));
         c_wd   = $urandom;
         d_wd   = $urandom;
         c_ctrl = 3'($urandom_range(0, 7));
         if (c_on && d_on) begin
`ifdef ARB_ROUND_ROBIN_EN
            core_first = !last_core;
`else
            core_first = 1'b1;
`endif
            last_core = !core_first;
         end else begin
            core_first = c_on;
            last_core  = c_on;
         end
         c_k = c_on ? (core_first ? LAT + 1 : 2 * LAT + 3) : 0;
         d_k = d_on ? (core_first ? 2 * LAT + 3 : LAT + 1) : 0;
         base = wr_count;
         nwr  = int'(c_on && c_we) + int'(d_on && d_we);
         coreReq = c_on; coreWe = c_we; coreAddr = {26'b0, c_idx, 2'b0}; coreWdata = c_wd; coreCtrl = c_ctrl;
         dmaReq = d_on; dmaWe = d_we; dmaAddr = {26'b0, d_idx, 2'b0}; dmaWdata = d_wd;
         for (int k = 1; k <= 2 * LAT + 4; k++) begin
            tick();
            checks++;
            if (coreAck !== (k == c_k) || dmaAck !== (k == d_k) || stallM !== (c_on && k < c_k)) begin
               failures++;
               $display("[TB] FAIL rand_timing it=%0d k=%0d cack=%b dack=%b stall=%b exp=%b/%b/%b",
                        it, k, coreAck, dmaAck, stallM, (k == c_k), (k == d_k), (c_on && k < c_k));
            end
            if (k == c_k) begin
               checks++;
               if (c_we) begin
                  if ({wr_addr, wr_data, wr_ctrl} !== {coreAddr, c_wd, c_ctrl}) begin
                     failures++;
                     $display("[TB] FAIL rand_core_write it=%0d got=%h/%h/%b exp=%h/%h/%b",
                              it, wr_addr, wr_data, wr_ctrl, coreAddr, c_wd, c_ctrl);
                  end
                  ref_mem[c_idx] = c_wd;
               end else if (coreRdata !== ref_mem[c_idx]) begin
                  failures++;
                  $display("[TB] FAIL rand_core_read it=%0d got=%h exp=%h", it, coreRdata, ref_mem[c_idx]);
               end
               coreReq = 0;
            end
            if (k == d_k) begin
               checks++;
               if (d_we) begin
                  if ({wr_addr, wr_data, wr_ctrl} !== {dmaAddr, d_wd, 3'b010}) begin
                     failures++;
                     $display("[TB] FAIL rand_dma_write it=%0d got=%h/%h/%b exp=%h/%h/010",
                              it, wr_addr, wr_data, wr_ctrl, dmaAddr, d_wd);
                  end
                  ref_mem[d_idx] = d_wd;
               end else if (dmaRdata !== ref_mem[d_idx]) begin
                  failures++;
                  $display("[TB] FAIL rand_dma_read it=%0d got=%h exp=%h", it, dmaRdata, ref_mem[d_idx]);
               end
               dmaReq = 0;
            end
         end
         checks++;
         if (wr_count !== base + nwr) begin
            failures++;
            $display("[TB] FAIL rand_write_count it=%0d got=%0d exp=%0d", it, wr_count - base, nwr);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         dev_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
         ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
      end
      dev_mem[4] = 32'hDEADBEEF;
      ref_mem[4] = 32'hDEADBEEF;
      idle_inputs();
      rst = 1;
      $display("[TB] starting data_mem_arbiter bench");
      test_reset();
      test_core_read();
      test_core_write();
      test_back_to_back();
      test_dma_then_core();
      test_reset_mid_access();
      test_lat1_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
